// File: rtl/w_wbq_pkg.sv
// Shared CPU definitions for the write-back queue: entry record, default depth
// and the hard-wired zero register number.
package w_wbq_pkg;

  localparam int         WBQ_DEPTH = 4;
  localparam logic [4:0] ZERO_REG  = 5'd0;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] wd;
    logic [31:0] pc;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over queue entries presented oldest-first; feeds one
// forwarding port (rs or rt) of the write-back queue.
module wbq_match
  import w_wbq_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic [4:0]       q_addr,
  input  logic [DEPTH-1:0] vld,
  input  logic [4:0]       dst [DEPTH],
  input  logic [31:0]      wd  [DEPTH],
  output logic             hit,
  output logic [31:0]      data
);

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Later (younger) matches override earlier ones.
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (q_addr != ZERO_REG) && (dst[i] == q_addr)) begin
        hit  = 1'b1;
        data = wd[i];
      end
    end
  end

endmodule

// File: rtl/w_wbq.sv
// Write-back queue: merges pipeline and long-latency write requests into one
// register-file write port, draining one entry per cycle, with forwarding lookup.
module w_wbq
  import w_wbq_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p_valid,
  output logic                     p_ready,
  input  logic [4:0]               p_dst,
  input  logic [31:0]              p_wd,
  input  logic [31:0]              p_pc,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [4:0]               m_dst,
  input  logic [31:0]              m_wd,
  input  logic [31:0]              m_pc,
  output logic [4:0]               regDst,
  output logic [31:0]              regWd,
  output logic [31:0]              wb_pc,
  input  logic [4:0]               q_rs,
  input  logic [4:0]               q_rt,
  output logic                     hit_rs,
  output logic                     hit_rt,
  output logic [31:0]              data_rs,
  output logic [31:0]              data_rt,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free;
  wbq_entry_t    out_q, out_d;
  wbq_entry_t    mem_q [DEPTH];
  wbq_entry_t    mem_d [DEPTH];
  logic          push_p, push_m, pop;

  logic [4:0]       ord_dst [DEPTH];
  logic [31:0]      ord_wd  [DEPTH];
  logic [DEPTH-1:0] ord_vld;

  // Space is judged on the registered count only; the same-cycle pop is not
  // credited, so the queue can never overflow even with two pushes.
  always_comb begin
    free    = CW'(DEPTH) - count_q;
    p_ready = (free >= CW'(1));
    m_ready = p_valid ? (free >= CW'(2)) : (free >= CW'(1));
  end

  always_comb begin
    push_p = p_valid && p_ready && (p_dst != ZERO_REG);
    push_m = m_valid && m_ready && (m_dst != ZERO_REG);
    pop    = (count_q != '0);

    mem_d = mem_q;
    // The pipeline entry is older, so it takes the first free slot.
    if (push_p) mem_d[wr_ptr_q] = '{dst: p_dst, wd: p_wd, pc: p_pc};
    if (push_m) mem_d[wr_ptr_q + PW'(push_p)] = '{dst: m_dst, wd: m_wd, pc: m_pc};

    wr_ptr_d = wr_ptr_q + PW'(push_p) + PW'(push_m);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_p) + CW'(push_m) - CW'(pop);
    out_d    = pop ? mem_q[rd_ptr_q] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q gates every read,
  // so stale contents are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Present queued entries oldest-first for the match search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord_dst[i] = mem_q[rd_ptr_q + PW'(i)].dst;
      ord_wd[i]  = mem_q[rd_ptr_q + PW'(i)].wd;
      ord_vld[i] = (CW'(i) < count_q);
    end
  end

  wbq_match #(.DEPTH(DEPTH)) u_match_rs (
    .q_addr (q_rs),
    .vld    (ord_vld),
    .dst    (ord_dst),
    .wd     (ord_wd),
    .hit    (hit_rs),
    .data   (data_rs)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match_rt (
    .q_addr (q_rt),
    .vld    (ord_vld),
    .dst    (ord_dst),
    .wd     (ord_wd),
    .hit    (hit_rt),
    .data   (data_rt)
  );

  assign regDst = out_q.dst;
  assign regWd  = out_q.wd;
  assign wb_pc  = out_q.pc;
  assign count  = count_q;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);

endmodule

// File: tb/tb_w_wbq.sv
// Bench for w_wbq: a directed vector table, a random phase, and an async reset
// sequence, all checked against a queue-based scoreboard.
module tb_w_wbq;
  import w_wbq_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_valid, m_valid;
  logic        p_ready, m_ready;
  logic [4:0]  p_dst, m_dst, q_rs, q_rt, regDst;
  logic [31:0] p_wd, p_pc, m_wd, m_pc, regWd, wb_pc, data_rs, data_rt;
  logic        hit_rs, hit_rt, full, empty;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  wbq_entry_t sb [$];

  typedef struct {
    logic        pv;
    logic [4:0]  pd;
    logic [31:0] pw, pp;
    logic        mv;
    logic [4:0]  md;
    logic [31:0] mw, mp;
    logic [4:0]  qs, qt;
    logic        e_pr, e_mr, e_hs;
    logic [31:0] e_ds;
    logic [4:0]  e_rd;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs [14];

  w_wbq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_ready(p_ready), .p_dst(p_dst), .p_wd(p_wd), .p_pc(p_pc),
    .m_valid(m_valid), .m_ready(m_ready), .m_dst(m_dst), .m_wd(m_wd), .m_pc(m_pc),
    .regDst(regDst), .regWd(regWd), .wb_pc(wb_pc),
    .q_rs(q_rs), .q_rt(q_rt), .hit_rs(hit_rs), .hit_rt(hit_rt),
    .data_rs(data_rs), .data_rt(data_rt),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_lookup(input logic [4:0] q, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (q != 5'd0)
      foreach (sb[i])
        if (sb[i].dst == q) begin
          hit = 1'b1;
          d   = sb[i].wd;
        end
  endfunction

  function automatic vec_t req(input logic pv, input logic [4:0] pd, input logic [31:0] pw, input logic [31:0] pp,
                               input logic mv, input logic [4:0] md, input logic [31:0] mw, input logic [31:0] mp,
                               input logic [4:0] qs, input logic [4:0] qt);
    vec_t v;
    v = '{pv, pd, pw, pp, mv, md, mw, mp, qs, qt, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 4'd0};
    return v;
  endfunction

  // Called at posedge+1: drive, check combinational outputs mid-cycle, then
  // update the scoreboard across the edge and check registered outputs.
  task automatic step(input vec_t v, input bit tab);
    logic        epr, emr, hs, ht;
    logic [31:0] ds, dt;
    wbq_entry_t  exp_o, e;
    int          n;
    p_valid = v.pv; p_dst = v.pd; p_wd = v.pw; p_pc = v.pp;
    m_valid = v.mv; m_dst = v.md; m_wd = v.mw; m_pc = v.mp;
    q_rs = v.qs; q_rt = v.qt;
    #4;
    n   = sb.size();
    epr = (n < DEPTH);
    emr = v.pv ? (n <= DEPTH - 2) : (n < DEPTH);
    model_lookup(v.qs, hs, ds);
    model_lookup(v.qt, ht, dt);
    check("p_ready", p_ready, epr);
    check("m_ready", m_ready, emr);
    check("hit_rs", hit_rs, hs);
    check("data_rs", data_rs, ds);
    check("hit_rt", hit_rt, ht);
    check("data_rt", data_rt, dt);
    if (tab) begin
      check("tab_p_ready", p_ready, v.e_pr);
      check("tab_m_ready", m_ready, v.e_mr);
      check("tab_hit_rs", hit_rs, v.e_hs);
      check("tab_data_rs", data_rs, v.e_ds);
    end
    @(posedge clk);
    exp_o = '0;
    if (sb.size() > 0) exp_o = sb.pop_front();
    if (v.pv && epr && v.pd != 5'd0) begin
      e = '{dst: v.pd, wd: v.pw, pc: v.pp};
      sb.push_back(e);
    end
    if (v.mv && emr && v.md != 5'd0) begin
      e = '{dst: v.md, wd: v.mw, pc: v.mp};
      sb.push_back(e);
    end
    #1;
    check("regDst", regDst, exp_o.dst);
    check("regWd", regWd, exp_o.wd);
    check("wb_pc", wb_pc, exp_o.pc);
    check("count", count, sb.size());
    check("full", full, sb.size() == DEPTH);
    check("empty", empty, sb.size() == 0);
    if (tab) begin
      check("tab_regDst", regDst, v.e_rd);
      check("tab_count", count, v.e_cnt);
    end
  endtask

  initial begin
    vec_t v;
    //          pv  pd  pw  pp        mv  md  mw  mp        qs  qt     pr mr hs ds        rd cnt
    vecs[0]  = '{1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'h0,  32'h0,   5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,    5'd0, 4'd1};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,  32'h0,   5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 32'h1234, 5'd5, 4'd0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,  32'h0,   5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,    5'd0, 4'd0};
    vecs[3]  = '{1'b1, 5'd3, 32'hA,    32'h100,  1'b1, 5'd3, 32'hB,  32'h104, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,    5'd0, 4'd2};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,  32'h0,   5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 32'hB,    5'd3, 4'd1};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,  32'h0,   5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 32'hB,    5'd3, 4'd0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,  32'h0,   5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,    5'd0, 4'd0};
    vecs[7]  = '{1'b1, 5'd0, 32'hFF,   32'h200,  1'b0, 5'd0, 32'h0,  32'h0,   5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,    5'd0, 4'd0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,  32'h0,   5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,    5'd0, 4'd0};
    vecs[9]  = '{1'b1, 5'd1, 32'h11,   32'h400,  1'b1, 5'd2, 32'h22, 32'h404, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0,    5'd0, 4'd2};
    vecs[10] = '{1'b1, 5'd4, 32'h44,   32'h408,  1'b1, 5'd6, 32'h66, 32'h40C, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 32'h11,   5'd1, 4'd3};
    vecs[11] = '{1'b1, 5'd7, 32'h77,   32'h410,  1'b1, 5'd8, 32'h88, 32'h414, 5'd4, 5'd8, 1'b1, 1'b0, 1'b1, 32'h44,   5'd2, 4'd3};
    vecs[12] = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,  32'h0,   5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 32'h77,   5'd4, 4'd2};
    vecs[13] = '{1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0, 32'h0,  32'h0,   5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,    5'd6, 4'd1};

    reset = 1'b0;
    p_valid = 1'b0; p_dst = '0; p_wd = '0; p_pc = '0;
    m_valid = 1'b0; m_dst = '0; m_wd = '0; m_pc = '0;
    q_rs = 5'd0; q_rt = 5'd0;
    #2;
    check("rst_regDst", regDst, 5'd0);
    check("rst_count", count, 3'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_hit_rs", hit_rs, 1'b0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) step(vecs[i], 1'b1);

    // Random traffic with frequent register collisions and zero destinations.
    for (int i = 0; i < 300; i++) begin
      v = req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom,
              1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom, $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step(v, 1'b0);
    end

    // Drain, then build occupancy 3 and pull reset mid-cycle.
    repeat (6) step(req(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step(req(1, 5'd9,  32'h90, 32'h500, 1, 5'd10, 32'hA0, 32'h504, 5'd9, 5'd10), 1'b0);
    step(req(1, 5'd11, 32'hB0, 32'h508, 1, 5'd12, 32'hC0, 32'h50C, 5'd9, 5'd10), 1'b0);
    check("pre_rst_count", count, 3'd3);
    check("pre_rst_regDst", regDst, 5'd9);
    p_valid = 1'b0; m_valid = 1'b0; q_rs = 5'd10;
    #2 reset = 1'b0;
    #1;
    check("async_regDst", regDst, 5'd0);
    check("async_regWd", regWd, 32'h0);
    check("async_wb_pc", wb_pc, 32'h0);
    check("async_count", count, 3'd0);
    check("async_empty", empty, 1'b1);
    check("async_hit_rs", hit_rs, 1'b0);
    sb.delete();
    @(posedge clk); #1;
    check("held_regDst", regDst, 5'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    repeat (3) step(req(0, 0, 0, 0, 0, 0, 0, 0, 5'd11, 5'd12), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
